feat_stream_out: RTL and testbench

Output stage directly downstream of the BRIEF descriptor stage. Captures each flagged keypoint record (coordinates, score, 256-bit descriptor) into an on-chip FIFO and serializes it onto a 32-bit valid/ready stream toward the host/DMA. Inserts an end-of-frame word carrying the frame's accepted-feature count, and counts features dropped on overflow.

---
 rtl/vo_pkg.sv | 53 +++++
 rtl/feat_stream_out_if.sv | 13 +
 rtl/feat_fifo.sv | 70 +++++++
 rtl/feat_stream_out.sv | 172 +++++++++++++++++
 tb/tb_feat_stream_out.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/vo_pkg.sv
// Shared types and helpers for the keypoint output stream: FIFO entry layout,
// read-side FSM states and the stream word formatters.
package vo_pkg;

    localparam logic [3:0]  TAG_FEAT   = 4'hA;
    localparam logic [3:0]  TAG_EOF    = 4'hF;
    localparam int unsigned DESC_WORDS = 8;
    localparam int unsigned STREAM_W   = 32;

    // EOF entries carry the 16-bit frame count in {y[5:0], x}
    typedef struct packed {
        logic         is_eof;
        logic [7:0]   score;
        logic [9:0]   y;
        logic [9:0]   x;
        logic [255:0] desc;
    } feat_entry_t;

    localparam int unsigned ENTRY_W = $bits(feat_entry_t);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_HEAD,
        RD_DESC,
        RD_EOFW
    } rd_state_e;

    function automatic feat_entry_t eof_entry(input logic [15:0] cnt);
        feat_entry_t e;
        e        = '0;
        e.is_eof = 1'b1;
        e.y[5:0] = cnt[15:10];
        e.x      = cnt[9:0];
        return e;
    endfunction

    function automatic logic [31:0] head_word(input logic       is_eof,
                                              input logic [7:0] score,
                                              input logic [9:0] y,
                                              input logic [9:0] x);
        if (is_eof) begin
            return {TAG_EOF, 12'h000, y[5:0], x};
        end
        return {TAG_FEAT, score, y, x};
    endfunction

    // idx 0..7 selects descriptor word 1..8, least significant word first
    function automatic logic [31:0] desc_word(input logic [255:0] d,
                                              input logic [2:0]   idx);
        return d[{idx, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/feat_stream_out_if.sv
// 32-bit valid/ready stream carrying serialized keypoint records.
interface feat_stream_out_if;
    import vo_pkg::*;

    logic                o_valid;
    logic                i_ready;
    logic [STREAM_W-1:0] o_data;
    logic                o_last;

    modport master (output o_valid, output o_data, output o_last, input  i_ready);
    modport slave  (input  o_valid, input  o_data, input  o_last, output i_ready);

endinterface

// File: rtl/feat_fifo.sv
// Single-clock FIFO with registered occupancy; exposes the head and the entry
// behind it so the reader can chain records without a bubble.
module feat_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [WIDTH-1:0]         o_next,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign o_full  = (level_q == LW'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_head  = mem_q[rd_ptr_q];
    assign o_next  = mem_q[rd_ptr_q + AW'(1)];

    always_comb begin
        do_push  = i_push && !o_full;
        do_pop   = i_pop && !o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

endmodule

// File: rtl/feat_stream_out.sv
// Captures flagged keypoint records into a FIFO and serializes them as 9-word
// feature records plus a 1-word end-of-frame record on a 32-bit stream.
module feat_stream_out
    import vo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flag,
    input  logic [9:0]             i_coor_x,
    input  logic [9:0]             i_coor_y,
    input  logic [7:0]             i_score,
    input  logic [255:0]           i_descriptor,
    input  logic                   i_frame_end,
    feat_stream_out_if.master      strm,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic [CNT_W-1:0]       o_drop_cnt
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    feat_entry_t      head, head_nxt, wr_entry, src;
    logic             fifo_full, fifo_empty;
    logic [LW-1:0]    fifo_level;
    logic             push, pop, push_feat, push_eof;

    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             eof_pending_q, eof_pending_d;

    rd_state_e        state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [31:0]      data_q, data_d;
    logic             last_q, last_d;
    logic             accept, adv, src_avail;

    feat_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_wdata (wr_entry),
        .i_pop   (pop),
        .o_head  (head),
        .o_next  (head_nxt),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (fifo_level)
    );

    // Write policy: features win the slot; EOF waits for a flag-free, non-full cycle
    always_comb begin
        push_feat     = i_flag && !fifo_full;
        push_eof      = eof_pending_q && !i_flag && !fifo_full;
        push          = push_feat || push_eof;
        frame_cnt_d   = frame_cnt_q;
        eof_pending_d = eof_pending_q;
        drop_cnt_d    = drop_cnt_q;
        wr_entry      = '0;

        if (push_eof) begin
            wr_entry = eof_entry(16'(frame_cnt_q));
        end else begin
            wr_entry.is_eof = 1'b0;
            wr_entry.score  = i_score;
            wr_entry.y      = i_coor_y;
            wr_entry.x      = i_coor_x;
            wr_entry.desc   = i_descriptor;
        end

        if (push_eof) begin
            frame_cnt_d   = '0;
            eof_pending_d = 1'b0;
        end else begin
            if (push_feat) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
            if (i_frame_end) begin
                eof_pending_d = 1'b1;
            end
        end

        if (i_flag && fifo_full && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // On the final accept of a record the next head is already visible, so the
    // following record is loaded in the same cycle the current one is popped.
    always_comb begin
        accept    = valid_q && strm.i_ready;
        adv       = accept && ((state_q == RD_EOFW) ||
                               ((state_q == RD_DESC) && (idx_q == 3'd7)));
        src       = adv ? head_nxt : head;
        src_avail = adv ? (fifo_level >= LW'(2)) : !fifo_empty;
        pop       = adv;

        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;

        case (state_q)
            RD_HEAD: begin
                if (accept) begin
                    state_d = RD_DESC;
                    idx_d   = 3'd0;
                    data_d  = desc_word(src.desc, 3'd0);
                    last_d  = 1'b0;
                end
            end
            RD_DESC: begin
                if (accept && !adv) begin
                    idx_d  = idx_q + 3'd1;
                    data_d = desc_word(src.desc, idx_q + 3'd1);
                    last_d = (idx_q == 3'd6);
                end
            end
            default: ;
        endcase

        if ((state_q == RD_IDLE) || adv) begin
            if (src_avail) begin
                valid_d = 1'b1;
                data_d  = head_word(src.is_eof, src.score, src.y, src.x);
                last_d  = src.is_eof;
                idx_d   = 3'd0;
                state_d = src.is_eof ? RD_EOFW : RD_HEAD;
            end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = RD_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= RD_IDLE;
            idx_q         <= '0;
            valid_q       <= 1'b0;
            data_q        <= '0;
            last_q        <= 1'b0;
            frame_cnt_q   <= '0;
            eof_pending_q <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            last_q        <= last_d;
            frame_cnt_q   <= frame_cnt_d;
            eof_pending_q <= eof_pending_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign strm.o_valid = valid_q;
    assign strm.o_data  = data_q;
    assign strm.o_last  = last_q;
    assign o_level      = fifo_level;
    assign o_full       = fifo_full;
    assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_feat_stream_out.sv
// Directed bench for feat_stream_out: expected stream words are queued when
// keypoints are driven and compared as the stream delivers them.
module tb_feat_stream_out;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flag;
    logic [9:0]       cx, cy;
    logic [7:0]       score;
    logic [255:0]     desc;
    logic             fe;
    logic [LW-1:0]    level;
    logic             full;
    logic [CNT_W-1:0] drop;

    feat_stream_out_if s_if ();

    feat_stream_out #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flag       (flag),
        .i_coor_x     (cx),
        .i_coor_y     (cy),
        .i_score      (score),
        .i_descriptor (desc),
        .i_frame_end  (fe),
        .strm         (s_if),
        .o_level      (level),
        .o_full       (full),
        .o_drop_cnt   (drop)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] exp_q [$];
    logic        stall_v = 1'b0;
    logic [32:0] stall_w;
    logic [32:0] mon_w;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_feat_exp(input logic [9:0] xx, input logic [9:0] yy,
                                 input logic [7:0] ss, input logic [255:0] dd);
        exp_q.push_back({1'b0, 4'hA, ss, yy, xx});
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({(k == 7), dd[32*k +: 32]});
        end
    endtask

    task automatic send(input logic [9:0] xx, input logic [9:0] yy, input logic [7:0] ss,
                        input logic [255:0] dd, input logic fe_in, input logic acc);
        flag  = 1'b1;
        cx    = xx;
        cy    = yy;
        score = ss;
        desc  = dd;
        fe    = fe_in;
        if (acc) push_feat_exp(xx, yy, ss, dd);
        tick();
        flag = 1'b0;
        fe   = 1'b0;
    endtask

    task automatic pulse_fe(input logic [31:0] eof_word);
        exp_q.push_back({1'b1, eof_word});
        fe = 1'b1;
        tick();
        fe = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", 64'(exp_q.size()), 64'(0));
        repeat (3) tick();
        check("idle_after_drain", 64'(s_if.o_valid), 64'(0));
    endtask

    function automatic logic [255:0] rand_desc();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    // Stream monitor: stall stability and in-order delivery against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                check("stall_valid", 64'(s_if.o_valid), 64'(1));
                check("stall_word", 64'({s_if.o_last, s_if.o_data}), 64'(stall_w));
            end
            if (s_if.o_valid && s_if.i_ready) begin
                check("sb_extra_word", 64'(exp_q.size() == 0), 64'(0));
                if (exp_q.size() != 0) begin
                    mon_w = exp_q.pop_front();
                    check("stream_word", 64'({s_if.o_last, s_if.o_data}), 64'(mon_w));
                end
            end
            stall_v = s_if.o_valid && !s_if.i_ready;
            stall_w = {s_if.o_last, s_if.o_data};
        end
    end

    initial begin
        logic [255:0] d1, d6;
        rst = 1'b1; flag = 1'b0; cx = '0; cy = '0; score = '0; desc = '0; fe = 1'b0;
        s_if.i_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_valid", 64'(s_if.o_valid), 64'(0));
        check("rst_data", 64'(s_if.o_data), 64'(0));
        check("rst_last", 64'(s_if.o_last), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_full", 64'(full), 64'(0));
        check("rst_drop", 64'(drop), 64'(0));
        rst = 1'b0;
        tick();

        // Single feature, ready high, first-word latency
        for (int k = 0; k < 8; k++) d1[32*k +: 32] = 32'h1111_1111 * (k + 1);
        s_if.i_ready = 1'b1;
        send(10'd100, 10'd50, 8'h33, d1, 1'b0, 1'b1);
        check("lat_pre_valid", 64'(s_if.o_valid), 64'(0));
        check("lat_level", 64'(level), 64'(1));
        tick();
        check("lat_valid", 64'(s_if.o_valid), 64'(1));
        check("lat_header", 64'(s_if.o_data), 64'(32'hA330C864));
        wait_drain(40);

        // Ready toggling every cycle during a record
        s_if.i_ready = 1'b0;
        send(10'd7, 10'd1023, 8'hFE, rand_desc(), 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            s_if.i_ready = ~s_if.i_ready;
            tick();
        end
        s_if.i_ready = 1'b1;
        wait_drain(40);

        // Overflow: 17 back-to-back flags with the stream stalled
        s_if.i_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send(10'(i), 10'(3 * i), 8'(i + 1), rand_desc(), 1'b0, (i < 16));
        end
        check("ovf_full", 64'(full), 64'(1));
        check("ovf_level", 64'(level), 64'(16));
        check("ovf_drop", 64'(drop), 64'(1));
        s_if.i_ready = 1'b1;
        wait_drain(400);

        // Close the frame so far: 1 + 1 + 16 accepted features
        pulse_fe(32'hF000_0012);
        wait_drain(20);

        // Three features then frame end
        for (int i = 0; i < 3; i++) begin
            send(10'(200 + i), 10'(300 + i), 8'(8'h40 + i), rand_desc(), 1'b0, 1'b1);
        end
        pulse_fe(32'hF000_0003);
        wait_drain(60);

        // Empty frame; a second frame_end while pending must not add an EOF
        pulse_fe(32'hF000_0000);
        fe = 1'b1;
        tick();
        fe = 1'b0;
        wait_drain(20);

        // Frame end coinciding with a flag, then one more flag
        send(10'd11, 10'd22, 8'h55, rand_desc(), 1'b1, 1'b1);
        send(10'd33, 10'd44, 8'h66, rand_desc(), 1'b0, 1'b1);
        exp_q.push_back({1'b1, 32'hF000_0002});
        wait_drain(60);

        // Reset while beat 4 of a record is presented
        d6 = rand_desc();
        send(10'd500, 10'd400, 8'h99, d6, 1'b0, 1'b1);
        repeat (5) tick();
        check("mid_beat4", 64'(s_if.o_data), 64'(d6[127:96]));
        rst = 1'b1;
        s_if.i_ready = 1'b0;
        tick();
        check("mid_rst_valid", 64'(s_if.o_valid), 64'(0));
        check("mid_rst_level", 64'(level), 64'(0));
        check("mid_rst_drop", 64'(drop), 64'(0));
        exp_q.delete();
        rst = 1'b0;
        s_if.i_ready = 1'b1;
        tick();
        send(10'd1, 10'd2, 8'h03, rand_desc(), 1'b0, 1'b1);
        wait_drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
